// File: rtl/trivium_keystream_scheduler.sv
// rtl/trivium_keystream_scheduler.sv - round-robin job scheduler sharing one trivium wrapper
module trivium_keystream_scheduler #(
  parameter int NREQ       = 2,
  parameter int DATA_WIDTH = 64,
  parameter int KEY_W      = 80,
  parameter int CNT_W      = 16,
  parameter int RST_CYC    = 4,
  parameter int TIMEOUT    = 4095,
  localparam int OW        = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NREQ-1:0]         req_valid,
  output logic [NREQ-1:0]         req_ready,
  input  logic [NREQ*KEY_W-1:0]   req_key,
  input  logic [NREQ*KEY_W-1:0]   req_iv,
  input  logic [NREQ*CNT_W-1:0]   req_nblocks,
  output logic                    blk_valid,
  input  logic                    blk_ready,
  output logic [DATA_WIDTH-1:0]   blk_data,
  output logic [OW-1:0]           blk_owner,
  output logic                    blk_last,
  output logic                    busy,
  output logic                    err_overrun,
  output logic                    err_timeout,
  output logic                    cipher_rst,
  output logic [KEY_W-1:0]        cipher_key,
  output logic [KEY_W-1:0]        cipher_iv,
  input  logic                    cipher_end,
  input  logic [DATA_WIDTH-1:0]   cipher_block
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int LW = (RST_CYC > 1) ? $clog2(RST_CYC) : 1;

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN} state_t;

  state_t                  state_q, state_d;
  logic [OW-1:0]           rr_q, rr_d;
  logic [OW-1:0]           owner_q, owner_d;
  logic [OW-1:0]           bowner_q, bowner_d;
  logic [CNT_W-1:0]        rem_q, rem_d;
  logic [LW-1:0]           ld_cnt_q, ld_cnt_d;
  logic [TW-1:0]           to_cnt_q, to_cnt_d;
  logic [KEY_W-1:0]        key_q, key_d;
  logic [KEY_W-1:0]        iv_q, iv_d;
  logic [DATA_WIDTH-1:0]   data_q, data_d;
  logic                    vld_q, vld_d;
  logic                    last_q, last_d;
  logic                    ovr_q, ovr_d;
  logic                    tmo_q, tmo_d;

  logic                    found;
  logic [OW-1:0]           win;
  logic [NREQ-1:0]         grant_oh;
  logic [KEY_W-1:0]        sel_key;
  logic [KEY_W-1:0]        sel_iv;
  logic [CNT_W-1:0]        sel_nb;
  logic                    grant;

  // Round-robin search: first asserted requester after rr_q, wrapping
  always_comb begin
    found = 1'b0;
    win   = '0;
    for (int k = 1; k <= NREQ; k++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!found && req_valid[i] && (((int'(rr_q) + k) % NREQ) == i)) begin
          found = 1'b1;
          win   = OW'(i);
        end
      end
    end
  end

  // Select the winning requester's job fields and its one-hot grant
  always_comb begin
    sel_key  = '0;
    sel_iv   = '0;
    sel_nb   = '0;
    grant_oh = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (OW'(i) == win) begin
        sel_key     = req_key[i*KEY_W +: KEY_W];
        sel_iv      = req_iv[i*KEY_W +: KEY_W];
        sel_nb      = req_nblocks[i*CNT_W +: CNT_W];
        grant_oh[i] = 1'b1;
      end
    end
  end

  // Never grant while a word is still waiting for the consumer
  assign grant     = (state_q == S_IDLE) && found && !vld_q;
  assign req_ready = (grant && rst) ? grant_oh : '0;

  // Next-state logic: arbitration, cipher reset sequencing, word capture, timeout
  always_comb begin
    state_d  = state_q;
    rr_d     = rr_q;
    owner_d  = owner_q;
    bowner_d = bowner_q;
    rem_d    = rem_q;
    ld_cnt_d = ld_cnt_q;
    to_cnt_d = to_cnt_q;
    key_d    = key_q;
    iv_d     = iv_q;
    data_d   = data_q;
    vld_d    = vld_q;
    last_d   = last_q;
    ovr_d    = ovr_q;
    tmo_d    = tmo_q;

    if (vld_q && blk_ready) begin
      vld_d = 1'b0;
    end

    case (state_q)
      S_IDLE: begin
        if (grant) begin
          rr_d    = win;
          owner_d = win;
          rem_d   = sel_nb;
          ovr_d   = 1'b0;
          tmo_d   = 1'b0;
          if (sel_nb != '0) begin
            key_d    = sel_key;
            iv_d     = sel_iv;
            ld_cnt_d = '0;
            state_d  = S_LOAD;
          end
        end
      end
      S_LOAD: begin
        if (ld_cnt_q == LW'(RST_CYC - 1)) begin
          to_cnt_d = '0;
          state_d  = S_RUN;
        end else begin
          ld_cnt_d = ld_cnt_q + 1'b1;
        end
      end
      S_RUN: begin
        if (cipher_end) begin
          to_cnt_d = '0;
          if (rem_q != '0) begin
            rem_d = rem_q - 1'b1;
          end
          if (!vld_q || blk_ready) begin
            data_d   = cipher_block;
            vld_d    = 1'b1;
            bowner_d = owner_q;
            last_d   = (rem_q == CNT_W'(1));
          end else begin
            ovr_d = 1'b1;
            if (rem_q == CNT_W'(1)) begin
              last_d = 1'b1;
            end
          end
          if (rem_q <= CNT_W'(1)) begin
            state_d = S_IDLE;
          end
        end else if (to_cnt_q >= TW'(TIMEOUT - 1)) begin
          to_cnt_d = TW'(TIMEOUT);
          tmo_d    = 1'b1;
          state_d  = S_IDLE;
        end else begin
          to_cnt_d = to_cnt_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers with asynchronous active-low reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      rr_q     <= OW'(NREQ - 1);
      owner_q  <= '0;
      bowner_q <= '0;
      rem_q    <= '0;
      ld_cnt_q <= '0;
      to_cnt_q <= '0;
      key_q    <= '0;
      iv_q     <= '0;
      data_q   <= '0;
      vld_q    <= 1'b0;
      last_q   <= 1'b0;
      ovr_q    <= 1'b0;
      tmo_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      rr_q     <= rr_d;
      owner_q  <= owner_d;
      bowner_q <= bowner_d;
      rem_q    <= rem_d;
      ld_cnt_q <= ld_cnt_d;
      to_cnt_q <= to_cnt_d;
      key_q    <= key_d;
      iv_q     <= iv_d;
      data_q   <= data_d;
      vld_q    <= vld_d;
      last_q   <= last_d;
      ovr_q    <= ovr_d;
      tmo_q    <= tmo_d;
    end
  end

  assign cipher_rst  = (state_q != S_RUN);
  assign busy        = (state_q != S_IDLE);
  assign cipher_key  = key_q;
  assign cipher_iv   = iv_q;
  assign blk_valid   = vld_q;
  assign blk_data    = data_q;
  assign blk_owner   = bowner_q;
  assign blk_last    = last_q;
  assign err_overrun = ovr_q;
  assign err_timeout = tmo_q;

endmodule
